game_score_timer: RTL and testbench

GAME_SCORE_TIMER -- requirements
Module: game_score_timer

---
 rtl/game_pkg.sv | 20 ++
 rtl/serial_divider.sv | 69 ++++++
 rtl/game_score_timer.sv | 160 ++++++++++++++++
 tb/tb_game_score_timer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state encoding and default constants for the game score timer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_FINISHED = 2'd3
  } game_state_t;

  localparam int DEF_CLK_FREQ_HZ = 50000000;
  localparam int DEF_GRACE_S     = 60;
  localparam int DEF_LIMIT_S     = 1800;
  localparam int DEF_MAX_SCORE   = 100;
  localparam int DEF_ERR_PENALTY = 5;
  localparam int DEF_TIMER_W     = 12;
  localparam int DEF_SCORE_W     = 8;
  localparam int DEF_ERR_W       = 4;

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider producing one quotient bit per cycle.
// start is taken only when idle; done pulses for one cycle with the quotient.
module serial_divider #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_r;
  logic [W-1:0]     dq_r;
  logic [W-1:0]     dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [W:0]       rem_sh_s;
  logic             q_bit_s;

  // Trial subtraction for the current quotient bit.
  always_comb begin
    rem_sh_s = {rem_r, dq_r[W-1]};
    if (rem_sh_s >= {1'b0, dvs_r}) begin
      q_bit_s = 1'b1;
    end else begin
      q_bit_s = 1'b0;
    end
  end

  // Iteration registers; dq_r shifts the dividend out and the quotient in.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      rem_r  <= {W{1'b0}};
      dq_r   <= {W{1'b0}};
      dvs_r  <= {W{1'b0}};
    end else if (start && !busy_r) begin
      busy_r <= 1'b1;
      done_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      rem_r  <= {W{1'b0}};
      dq_r   <= dividend;
      dvs_r  <= divisor;
    end else if (busy_r) begin
      rem_r  <= q_bit_s ? W'(rem_sh_s - {1'b0, dvs_r}) : rem_sh_s[W-1:0];
      dq_r   <= {dq_r[W-2:0], q_bit_s};
      cnt_r  <= cnt_r + CNT_W'(1);
      done_r <= (cnt_r == CNT_W'(W - 1));
      busy_r <= (cnt_r != CNT_W'(W - 1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign quotient = dq_r;

endmodule

// File: rtl/game_score_timer.sv
// Game clock and score keeper: counts game seconds and errors, and derives a
// time-decaying score through a serial divider with a pending-recompute flag.
module game_score_timer
  import game_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int GRACE_S     = DEF_GRACE_S,
  parameter int LIMIT_S     = DEF_LIMIT_S,
  parameter int MAX_SCORE   = DEF_MAX_SCORE,
  parameter int ERR_PENALTY = DEF_ERR_PENALTY,
  parameter int TIMER_W     = DEF_TIMER_W,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int ERR_W       = DEF_ERR_W
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               finish,
  input  logic               error_pulse,
  output logic [TIMER_W-1:0] timer,
  output logic [SCORE_W-1:0] score,
  output logic [ERR_W-1:0]   errors,
  output logic [1:0]         state,
  output logic               score_valid
);

  localparam int NUM_W  = TIMER_W + SCORE_W;
  localparam int CALC_W = NUM_W + ERR_W + 32;
  localparam int PRE_W  = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;

  localparam logic [PRE_W-1:0]   PRE_TC     = PRE_W'(CLK_FREQ_HZ - 1);
  localparam logic [TIMER_W-1:0] GRACE_C    = TIMER_W'(GRACE_S);
  localparam logic [TIMER_W-1:0] LIMIT_M1_C = TIMER_W'(LIMIT_S - 1);
  localparam logic [NUM_W-1:0]   SPAN_C     = NUM_W'(LIMIT_S - GRACE_S);
  localparam logic [NUM_W-1:0]   MAX_N_C    = NUM_W'(MAX_SCORE);
  localparam logic [CALC_W-1:0]  MAX_C      = CALC_W'(MAX_SCORE);
  localparam logic [CALC_W-1:0]  PEN_C      = CALC_W'(ERR_PENALTY);
  localparam logic [ERR_W-1:0]   ERR_MAX_C  = {ERR_W{1'b1}};

  game_state_t        state_r, state_nxt_s;
  logic [PRE_W-1:0]   presc_r;
  logic [TIMER_W-1:0] timer_r, tdiff_s;
  logic [ERR_W-1:0]   errors_r, err_snap_r;
  logic [SCORE_W-1:0] score_r;
  logic               valid_r, pend_r;
  logic               run_s, tick_s, game_start_s, tick_apply_s, err_apply_s;
  logic               chg_s, sat_s, div_start_s, div_busy_s, div_done_s;
  logic [NUM_W-1:0]   num_s, quo_s;
  logic [CALC_W-1:0]  base_s, pen_s, final_s;

  // Event decode and score arithmetic; finish suppresses same-cycle updates.
  always_comb begin
    run_s        = (state_r == ST_RUNNING);
    tick_s       = run_s && (presc_r == PRE_TC);
    game_start_s = start && ((state_r == ST_IDLE) || (state_r == ST_FINISHED));
    tick_apply_s = tick_s && !finish;
    err_apply_s  = run_s && error_pulse && !finish && (errors_r != ERR_MAX_C);
    chg_s        = tick_apply_s || err_apply_s;
    sat_s        = tick_apply_s && (timer_r == LIMIT_M1_C);
    div_start_s  = pend_r && !div_busy_s && !game_start_s;
    tdiff_s      = timer_r - GRACE_C;
    // At the limit the quotient equals MAX_SCORE, so the base drops to 0.
    if (timer_r > GRACE_C) begin
      num_s = NUM_W'(tdiff_s) * MAX_N_C;
    end else begin
      num_s = {NUM_W{1'b0}};
    end
    base_s = MAX_C - CALC_W'(quo_s);
    pen_s  = CALC_W'(err_snap_r) * PEN_C;
    if (base_s > pen_s) begin
      final_s = base_s - pen_s;
    end else begin
      final_s = {CALC_W{1'b0}};
    end
  end

  // Next-state logic for the game FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUNNING;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUNNING: begin
        if (finish || sat_s) state_nxt_s = ST_FINISHED;
        else if (pause)      state_nxt_s = ST_PAUSED;
        else                 state_nxt_s = ST_RUNNING;
      end
      ST_PAUSED: begin
        if (finish)      state_nxt_s = ST_FINISHED;
        else if (!pause) state_nxt_s = ST_RUNNING;
        else             state_nxt_s = ST_PAUSED;
      end
      ST_FINISHED: begin
        if (start) state_nxt_s = ST_RUNNING;
        else       state_nxt_s = ST_FINISHED;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_50MHz) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Prescaler, counters and recompute bookkeeping.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      presc_r    <= {PRE_W{1'b0}};
      timer_r    <= {TIMER_W{1'b0}};
      errors_r   <= {ERR_W{1'b0}};
      err_snap_r <= {ERR_W{1'b0}};
      score_r    <= {SCORE_W{1'b0}};
      valid_r    <= 1'b0;
      pend_r     <= 1'b0;
    end else if (game_start_s) begin
      presc_r    <= {PRE_W{1'b0}};
      timer_r    <= {TIMER_W{1'b0}};
      errors_r   <= {ERR_W{1'b0}};
      err_snap_r <= {ERR_W{1'b0}};
      score_r    <= SCORE_W'(MAX_SCORE);
      valid_r    <= 1'b1;
      pend_r     <= 1'b0;
    end else begin
      if (run_s) presc_r <= tick_s ? {PRE_W{1'b0}} : presc_r + PRE_W'(1);
      if (tick_apply_s) timer_r <= timer_r + TIMER_W'(1);
      if (err_apply_s) errors_r <= errors_r + ERR_W'(1);
      if (div_start_s) err_snap_r <= errors_r;
      // pend_r set on completion means the result is stale: discard it.
      if (chg_s)            pend_r <= 1'b1;
      else if (div_start_s) pend_r <= 1'b0;
      if (div_done_s && !pend_r) score_r <= SCORE_W'(final_s);
      if (chg_s)                      valid_r <= 1'b0;
      else if (div_done_s && !pend_r) valid_r <= 1'b1;
    end
  end

  serial_divider #(.W(NUM_W)) u_div (
    .clk      (clk_50MHz),
    .reset    (reset),
    .clr      (game_start_s),
    .start    (div_start_s),
    .dividend (num_s),
    .divisor  (SPAN_C),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (quo_s)
  );

  assign timer       = timer_r;
  assign score       = score_r;
  assign errors      = errors_r;
  assign state       = state_r;
  assign score_valid = valid_r;

endmodule

// File: tb/tb_game_score_timer.sv
// Directed bench for game_score_timer with a 4-cycle game second.
module tb_game_score_timer;

  logic        clk_50MHz = 1'b0;
  logic        reset, start, pause, finish, error_pulse;
  logic [11:0] timer;
  logic [7:0]  score;
  logic [3:0]  errors;
  logic [1:0]  state;
  logic        score_valid;
  int          total = 0;
  int          bad = 0;

  always #5 clk_50MHz = ~clk_50MHz;

  game_score_timer #(
    .CLK_FREQ_HZ(4), .GRACE_S(2), .LIMIT_S(6), .MAX_SCORE(100), .ERR_PENALTY(5),
    .TIMER_W(12), .SCORE_W(8), .ERR_W(4)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .start(start), .pause(pause),
    .finish(finish), .error_pulse(error_pulse), .timer(timer), .score(score),
    .errors(errors), .state(state), .score_valid(score_valid)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic end_game;
    pause = 1'b0; finish = 1'b1; step(1); finish = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (score_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; step(3); start = 1'b0; reset = 1'b0;
    total += 1; if (state !== 2'd0) begin bad += 1; $display("FAIL reset_state: got %0d want 0", state); end
    total += 1; if (timer !== 12'd0 || errors !== 4'd0) begin bad += 1; $display("FAIL reset_cnt: timer %0d errors %0d want 0 0", timer, errors); end
    total += 1; if (score !== 8'd0 || score_valid !== 1'b0) begin bad += 1; $display("FAIL reset_score: score %0d valid %0b want 0 0", score, score_valid); end
  endtask

  task automatic test_run;
    bit ok;
    pulse_start();
    total += 1; if (state !== 2'd1 || score !== 8'd100 || score_valid !== 1'b1) begin bad += 1; $display("FAIL start_out: state %0d score %0d valid %0b want 1 100 1", state, score, score_valid); end
    step(5);
    total += 1; if (score_valid !== 1'b0) begin bad += 1; $display("FAIL run_busy: valid %0b want 0", score_valid); end
    step(7);
    total += 1; if (timer !== 12'd3) begin bad += 1; $display("FAIL run_timer: got %0d want 3", timer); end
    pause = 1'b1; step(1);
    total += 1; if (state !== 2'd2) begin bad += 1; $display("FAIL run_pause: state %0d want 2", state); end
    wait_valid(ok);
    total += 1; if (!ok) begin bad += 1; $display("FAIL run_valid: timeout got 0 want 1"); end
    total += 1; if (score !== 8'd75 || timer !== 12'd3) begin bad += 1; $display("FAIL run_score: score %0d timer %0d want 75 3", score, timer); end
    end_game();
  endtask

  task automatic test_pause;
    int held_bad;
    pulse_start();
    step(6);
    pause = 1'b1; step(1);
    total += 1; if (state !== 2'd2) begin bad += 1; $display("FAIL pause_state: got %0d want 2", state); end
    held_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (timer !== 12'd1) held_bad += 1;
    end
    total += 1; if (held_bad != 0) begin bad += 1; $display("FAIL pause_hold: %0d cycles off, want timer 1", held_bad); end
    pause = 1'b0; step(1);
    total += 1; if (timer !== 12'd1 || state !== 2'd1) begin bad += 1; $display("FAIL pause_release: timer %0d state %0d want 1 1", timer, state); end
    step(1);
    total += 1; if (timer !== 12'd2) begin bad += 1; $display("FAIL pause_resume: timer %0d want 2", timer); end
    end_game();
  endtask

  task automatic test_errors;
    bit ok;
    pulse_start();
    step(4);
    error_pulse = 1'b1; step(2);
    pause = 1'b1; step(1); error_pulse = 1'b0;
    total += 1; if (errors !== 4'd3 || timer !== 12'd1) begin bad += 1; $display("FAIL err_count: errors %0d timer %0d want 3 1", errors, timer); end
    wait_valid(ok);
    total += 1; if (!ok || score !== 8'd85) begin bad += 1; $display("FAIL err_score: score %0d valid %0b want 85 1", score, ok); end
    error_pulse = 1'b1; step(1); error_pulse = 1'b0;
    total += 1; if (errors !== 4'd3) begin bad += 1; $display("FAIL err_paused: errors %0d want 3", errors); end
    end_game();
  endtask

  task automatic test_timeout;
    bit ok;
    pulse_start();
    step(9);
    start = 1'b1; step(1); start = 1'b0;
    step(13);
    total += 1; if (timer !== 12'd5 || state !== 2'd1) begin bad += 1; $display("FAIL to_pre: timer %0d state %0d want 5 1", timer, state); end
    step(1);
    total += 1; if (timer !== 12'd6 || state !== 2'd3) begin bad += 1; $display("FAIL to_limit: timer %0d state %0d want 6 3", timer, state); end
    wait_valid(ok);
    total += 1; if (!ok || score !== 8'd0) begin bad += 1; $display("FAIL to_score: score %0d valid %0b want 0 1", score, ok); end
    error_pulse = 1'b1; step(3); error_pulse = 1'b0;
    step(10);
    total += 1; if (timer !== 12'd6 || errors !== 4'd0 || state !== 2'd3 || score_valid !== 1'b1 || score !== 8'd0) begin
      bad += 1; $display("FAIL to_frozen: timer %0d errors %0d state %0d valid %0b score %0d want 6 0 3 1 0", timer, errors, state, score_valid, score);
    end
  endtask

  task automatic test_finish_tick;
    bit ok;
    pulse_start();
    step(19);
    finish = 1'b1; error_pulse = 1'b1; step(1); finish = 1'b0; error_pulse = 1'b0;
    total += 1; if (timer !== 12'd4 || errors !== 4'd0 || state !== 2'd3) begin bad += 1; $display("FAIL fin_tick: timer %0d errors %0d state %0d want 4 0 3", timer, errors, state); end
    wait_valid(ok);
    total += 1; if (!ok || score !== 8'd50) begin bad += 1; $display("FAIL fin_score: score %0d valid %0b want 50 1", score, ok); end
  endtask

  task automatic test_pending_reset;
    bit ok;
    pulse_start();
    step(5);
    error_pulse = 1'b1; pause = 1'b1; step(1); error_pulse = 1'b0;
    total += 1; if (errors !== 4'd1 || score_valid !== 1'b0) begin bad += 1; $display("FAIL pend_busy: errors %0d valid %0b want 1 0", errors, score_valid); end
    wait_valid(ok);
    total += 1; if (!ok || score !== 8'd95) begin bad += 1; $display("FAIL pend_score: score %0d valid %0b want 95 1", score, ok); end
    end_game();
    pulse_start();
    step(6);
    total += 1; if (score_valid !== 1'b0) begin bad += 1; $display("FAIL rst_busy: valid %0b want 0", score_valid); end
    reset = 1'b1; step(1); reset = 1'b0;
    total += 1; if (state !== 2'd0 || score !== 8'd0 || score_valid !== 1'b0 || timer !== 12'd0) begin
      bad += 1; $display("FAIL rst_mid: state %0d score %0d valid %0b timer %0d want 0 0 0 0", state, score, score_valid, timer);
    end
    step(40);
    total += 1; if (score_valid !== 1'b0 || score !== 8'd0 || state !== 2'd0) begin bad += 1; $display("FAIL rst_abort: valid %0b score %0d state %0d want 0 0 0", score_valid, score, state); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; finish = 1'b0; error_pulse = 1'b0;
    test_reset();
    test_run();
    test_pause();
    test_errors();
    test_timeout();
    test_finish_tick();
    test_pending_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
